// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_arbiter
// Purpose  : Serialises whole-line miss/writeback requests from the split L1
//            caches (I-cache read only, D-cache read or write) onto a single
//            line-wide physical-memory port. Ties are broken round-robin, and
//            every transaction is followed by a one-cycle recovery bubble.
// Ports    : clk, rst (async, active low)
//            I-cache side : i_pmem_read, i_pmem_address -> i_pmem_rdata,
//                           i_pmem_resp
//            D-cache side : d_pmem_read, d_pmem_write, d_pmem_address,
//                           d_pmem_wdata -> d_pmem_rdata, d_pmem_resp
//            Memory side  : pmem_read, pmem_write, pmem_address, pmem_wdata
//                           <- pmem_rdata, pmem_resp
// Revision : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_e state_q;
    logic   last_grant_q;

    logic   w_i_req;
    logic   w_d_req;
    logic   w_grant_i;
    logic   w_grant_d;

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

    // On a tie the side that did not win last time gets the memory; with
    // only one side requesting it wins regardless of history.
    assign w_grant_d = (state_q == IDLE) && w_d_req &&
                       (!w_i_req || (last_grant_q == GRANT_I));
    assign w_grant_i = (state_q == IDLE) && w_i_req && !w_grant_d;

    // Completion is forwarded in the same cycle memory reports it, and only
    // to the side currently being served.
    assign i_pmem_resp  = (state_q == SERVE_I) && pmem_resp;
    assign d_pmem_resp  = (state_q == SERVE_D) && pmem_resp;

    // Read data is a plain pass-through; caches qualify it with their resp.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            last_grant_q <= GRANT_I;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_grant_d) begin
                        // Address, data and direction are captured here so
                        // the memory sees stable values for the whole
                        // transaction. A simultaneous read+write is treated
                        // as a write.
                        state_q      <= SERVE_D;
                        pmem_write   <= d_pmem_write;
                        pmem_read    <= ~d_pmem_write;
                        pmem_address <= d_pmem_address;
                        pmem_wdata   <= d_pmem_wdata;
                        last_grant_q <= GRANT_D;
                    end else if (w_grant_i) begin
                        state_q      <= SERVE_I;
                        pmem_read    <= 1'b1;
                        pmem_write   <= 1'b0;
                        pmem_address <= i_pmem_address;
                        last_grant_q <= GRANT_I;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state_q    <= RECOVER;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                RECOVER: begin
                    // Bubble gives the finished cache a cycle to drop its
                    // request before the next arbitration.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // A D-cache asking to read and write the same line at once is a
    // protocol error upstream.
    always @(posedge clk) begin
        if (rst && w_grant_d) begin
            assert (!(d_pmem_read && d_pmem_write));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_arbiter
// Purpose  : Self-checking bench for cache_arbiter. Directed scenarios first,
//            then randomised cache/memory traffic, all compared every cycle
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_pmem_read = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int i_resp_cnt  = 0;   // DUT i_pmem_resp pulses seen
    int d_resp_cnt  = 0;   // DUT d_pmem_resp pulses seen

    // ---------------- reference model (transaction level) ----------------
    // owner: who holds the memory (0 nobody, 1 I-cache, 2 D-cache)
    int            m_owner;
    bit            m_bubble;     // a transaction just ended; nobody may win
    bit            m_last_d;     // most recent winner was the D-cache
    bit            m_wr;         // D transaction is a writeback
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    bit            ev_i, ev_d;   // model says the side just completed

    task automatic model_reset();
        m_owner  = 0;
        m_bubble = 0;
        m_last_d = 0;
        m_wr     = 0;
        m_addr   = '0;
        m_wdata  = '0;
        ev_i     = 0;
        ev_d     = 0;
    endtask

    task automatic model_update();
        bit ireq, dreq;
        ev_i = 0;
        ev_d = 0;
        if (!rst) begin
            model_reset();
        end else if (m_bubble) begin
            m_bubble = 0;
        end else if (m_owner == 0) begin
            ireq = i_pmem_read;
            dreq = d_pmem_read | d_pmem_write;
            if (dreq && (!ireq || !m_last_d)) begin
                m_owner  = 2;
                m_last_d = 1;
                m_wr     = d_pmem_write;
                m_addr   = d_pmem_address;
                m_wdata  = d_pmem_wdata;
            end else if (ireq) begin
                m_owner  = 1;
                m_last_d = 0;
                m_addr   = i_pmem_address;
            end
        end else if (pmem_resp) begin
            ev_i     = (m_owner == 1);
            ev_d     = (m_owner == 2);
            m_owner  = 0;
            m_bubble = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the
    // rising edge, return 1 time unit later so callers can drive inputs.
    task automatic step();
        @(negedge clk);
        chk("pmem_read",    LW'(pmem_read),  LW'((m_owner == 1) || (m_owner == 2 && !m_wr)));
        chk("pmem_write",   LW'(pmem_write), LW'(m_owner == 2 && m_wr));
        chk("pmem_address", LW'(pmem_address), LW'(m_addr));
        chk("pmem_wdata",   pmem_wdata, m_wdata);
        chk("i_pmem_resp",  LW'(i_pmem_resp), LW'(rst && m_owner == 1 && !m_bubble && pmem_resp));
        chk("d_pmem_resp",  LW'(d_pmem_resp), LW'(rst && m_owner == 2 && !m_bubble && pmem_resp));
        chk("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
        chk("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
        i_resp_cnt += int'(i_pmem_resp);
        d_resp_cnt += int'(d_pmem_resp);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin : main
        int  base;
        bit  i_pend, d_pend;
        logic [LW-1:0] wd;

        model_reset();

        // --- reset held with I requesting: nothing may reach memory ---
        rst = 0; i_pmem_read = 1; i_pmem_address = 32'h0000_0060;
        repeat (3) step();
        chk("reset_no_resp", LW'(i_resp_cnt), LW'(0));

        // --- release: I granted, memory answers after 5 cycles with AA.. ---
        rst = 1;
        step();
        chk("first_grant_addr", LW'(pmem_address), LW'(32'h0000_0060));
        chk("first_grant_read", LW'(pmem_read), LW'(1));
        repeat (4) step();
        pmem_rdata = {32{8'hAA}};
        pmem_resp  = 1;
        step();
        pmem_resp = 0; i_pmem_read = 0;
        step(); step();
        chk("i_single_resp", LW'(i_resp_cnt), LW'(1));
        chk("d_no_resp",     LW'(d_resp_cnt), LW'(0));

        // --- D writeback; cache inputs wander mid-transaction ---
        wd = {8{32'h1234_5678}};
        d_pmem_write = 1; d_pmem_address = 32'h0000_1000; d_pmem_wdata = wd;
        step();
        d_pmem_wdata = ~wd; d_pmem_address = 32'hDEAD_0000;
        repeat (3) step();
        chk("wb_wdata_held", pmem_wdata, wd);
        chk("wb_write",      LW'(pmem_write), LW'(1));
        pmem_resp = 1;
        step();
        pmem_resp = 0; d_pmem_write = 0;
        step(); step();
        chk("d_single_resp", LW'(d_resp_cnt), LW'(1));

        // --- reset again so the tie starts from last_grant = I ---
        rst = 0; model_reset();
        step();
        rst = 1;
        i_pmem_read = 1; i_pmem_address = 32'h0000_0200;
        d_pmem_read = 1; d_pmem_address = 32'h0000_0300;
        step();
        chk("tie1_d_wins", LW'(pmem_address), LW'(32'h0000_0300));
        pmem_resp = 1;
        step();                      // d_pmem_resp cycle
        pmem_resp = 0; d_pmem_read = 0;
        step();                      // RECOVER
        step();                      // IDLE grant to the waiting I
        chk("tie1_i_next", LW'(pmem_address), LW'(32'h0000_0200));
        pmem_resp = 1;
        step();
        pmem_resp = 0; i_pmem_read = 0;
        step(); step();
        i_pmem_read = 1; i_pmem_address = 32'h0000_0400;
        d_pmem_read = 1; d_pmem_address = 32'h0000_0500;
        step();
        chk("tie2_d_wins", LW'(pmem_address), LW'(32'h0000_0500));
        pmem_resp = 1;
        step();
        pmem_resp = 0; d_pmem_read = 0;
        step(); step();
        pmem_resp = 1;
        step();
        pmem_resp = 0; i_pmem_read = 0;
        step(); step();

        // --- reset mid SERVE_D, then a stray memory response ---
        base = d_resp_cnt;
        d_pmem_read = 1; d_pmem_address = 32'h0000_0700;
        step(); step();
        rst = 0; model_reset();
        #1;
        chk("rst_mid_read",  LW'(pmem_read),  LW'(0));
        chk("rst_mid_write", LW'(pmem_write), LW'(0));
        d_pmem_read = 0; pmem_resp = 1;
        step();
        rst = 1;
        step();
        pmem_resp = 0;
        step();
        chk("rst_abandon", LW'(d_resp_cnt - base), LW'(0));

        // --- zero-wait memory, I request held continuously ---
        base = i_resp_cnt;
        i_pmem_read = 1; i_pmem_address = 32'h0000_0800; pmem_resp = 1;
        repeat (9) step();
        chk("zero_wait_rate", LW'(i_resp_cnt - base), LW'(3));
        i_pmem_read = 0; pmem_resp = 0;
        rst = 0; model_reset();
        step();
        rst = 1;

        // --- randomised traffic ---
        i_pend = 0; d_pend = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (ev_i) begin
                i_pend = 0; i_pmem_read = 0;
            end else if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_pmem_read = 1;
                i_pmem_address = $urandom;
            end
            if (ev_d) begin
                d_pend = 0; d_pmem_read = 0; d_pmem_write = 0;
            end else if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                d_pmem_write = $urandom_range(0, 1) == 1;
                d_pmem_read  = !d_pmem_write;
                d_pmem_address = $urandom;
                d_pmem_wdata   = {8{$urandom}};
            end else if (d_pend && $urandom_range(0, 3) == 0) begin
                d_pmem_address = $urandom;
                d_pmem_wdata   = {8{$urandom}};
            end
            pmem_rdata = {8{$urandom}};
            pmem_resp  = $urandom_range(0, 2) == 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Sits between the split L1 caches and the single physical-memory port.
- The caches serve the pipeline's inst_read/inst_addr and data_read/data_write/data_addr ports.
- Accepts whole-line miss/writeback requests from the I-cache (read only) and the D-cache (read or write), and serialises them onto one line-wide memory interface.
- Round-robin arbitration; one-cycle recovery bubble after every transaction.

Parameters:
- LINE_W, 256, cache line width in bits (data path width on all three sides).
- ADDR_W, 32, line address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_pmem_read  in  1  I-cache line read request; held until i_pmem_resp.
- i_pmem_address  in  ADDR_W  I-cache line address.
- i_pmem_rdata  out  LINE_W  line data to I-cache.
- i_pmem_resp  out  1  I-cache completion pulse.
- d_pmem_read  in  1  D-cache line read request; held until d_pmem_resp.
- d_pmem_write  in  1  D-cache line writeback request; held until d_pmem_resp.
- d_pmem_address  in  ADDR_W  D-cache line address.
- d_pmem_wdata  in  LINE_W  D-cache writeback data.
- d_pmem_rdata  out  LINE_W  line data to D-cache.
- d_pmem_resp  out  1  D-cache completion pulse.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_W  memory line address.
- pmem_wdata  out  LINE_W  memory write data.
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory completion; one cycle.

Behaviour:
- Clocking and reset:
  - Single clock domain, rising edge.
  - rst low asynchronously forces: state IDLE, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, last_grant=I, i_pmem_resp=0, d_pmem_resp=0.
- FSM states: IDLE, SERVE_I, SERVE_D, RECOVER.
- IDLE:
  - No strobes driven; pmem_resp is ignored.
  - Only I requesting: go to SERVE_I.
  - Only D (read or write) requesting: go to SERVE_D.
  - Both requesting: grant the side opposite last_grant. Since last_grant resets to I, D wins the first tie.
  - On grant, register the winner's address (and d_pmem_wdata and the direction for D) into the pmem_* output registers.
  - Update last_grant on grant.
- Latency: a request first seen in IDLE at cycle N gets its pmem strobe asserted from cycle N+1.
- SERVE_I:
  - pmem_read=1; pmem_address holds the latched value; pmem_write=0.
  - On pmem_resp: i_pmem_resp=1 in that same cycle (combinational), then go to RECOVER.
- SERVE_D:
  - pmem_write=1 if d_pmem_write was high at grant, else pmem_read=1.
  - Address and wdata hold the latched values, stable for the whole transaction even if cache inputs change.
  - On pmem_resp: d_pmem_resp=1 in the same cycle, then go to RECOVER.
- RECOVER:
  - Exactly one cycle; no strobes, no grants.
  - Lets the cache drop its request before re-arbitration. Then go to IDLE.
- Response signals:
  - i_pmem_resp and d_pmem_resp are never high outside their SERVE state, and never high together.
  - Each pulses exactly one cycle per transaction.
- Read data: i_pmem_rdata and d_pmem_rdata are continuous pass-through of pmem_rdata; valid only while the matching resp is high.
- Boundary conditions:
  - d_pmem_read and d_pmem_write both high at grant is illegal. Write takes precedence, and the simulation-only assertion fires.
  - A request arriving while the other side is in service waits; it is granted in the IDLE cycle after RECOVER.
  - Worst-case wait is one full opposite transaction plus 2 cycles.
  - pmem_resp in IDLE or RECOVER is dropped; no cache resp is generated.
  - Reset asserted mid-SERVE: strobes drop immediately, and the in-flight request is abandoned (no resp). The requesting cache must re-issue after reset.
  - Back-to-back requests from the same side with the other side idle are each served; last_grant does not block them.
  - Zero-wait memory (pmem_resp in the first SERVE cycle) is legal: total transaction is 3 cycles (IDLE grant, SERVE, RECOVER).

Test Plan:
- Reset: hold rst=0 with i_pmem_read=1 → pmem_read=0, i_pmem_resp=0. Release at cycle 0 → pmem_read=1, pmem_address=i_pmem_address from cycle 1.
- I read 0x0000_0060, memory resp after 5 cycles with data 0xAA..AA → i_pmem_resp high exactly 1 cycle, i_pmem_rdata=0xAA..AA, d_pmem_resp stays 0.
- D write 0x0000_1000 with wdata 0x1234..; bench changes d_pmem_wdata mid-transaction → pmem_write=1, and pmem_wdata holds the original value until pmem_resp.
- I and D requests asserted in the same cycle after reset → D served first. Then I is granted 2 cycles after d_pmem_resp (RECOVER, then IDLE grant). A second simultaneous tie is then won by D, since last_grant=I.
- Reset pulsed mid-SERVE_D, followed by a stray pmem_resp → no d_pmem_resp, state IDLE, strobes 0.
- pmem_resp in the first SERVE cycle with I requests held continuously → one I transaction every 3 cycles, one resp per transaction.
